// File: rtl/axi_slv_rd_arb_if.sv
// axi_slv_rd_arb_if
//   Bundle of AXI read-address and read-data signals for LANES requesters.
//   Per-lane handshakes are LANES bits wide. AR payloads are packed, with
//   lane i at slice i. The R payload is a single broadcast copy.
//   modport master : drives AR and rready (the requesting side)
//   modport slave  : drives arready and R (the responding side)
// Ports (signals):
//   arvalid/arready [LANES], araddr [LANES*ADDR_W], arlen [LANES*4],
//   arid [LANES*ID_W], rvalid/rready [LANES], rdata [DATA_W], rid [ID_W],
//   rresp [2], rlast [1]
interface axi_slv_rd_arb_if #(
  parameter int LANES  = 1,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
);
  logic [LANES-1:0]        arvalid;
  logic [LANES-1:0]        arready;
  logic [LANES*ADDR_W-1:0] araddr;
  logic [LANES*4-1:0]      arlen;
  logic [LANES*ID_W-1:0]   arid;
  logic [LANES-1:0]        rvalid;
  logic [LANES-1:0]        rready;
  logic [DATA_W-1:0]       rdata;
  logic [ID_W-1:0]         rid;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output arvalid, araddr, arlen, arid, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi_slv_rd_arb.sv
// axi_slv_rd_arb
//   Shares one AXI slave read port among MST_NUM masters. One pending AR
//   request is granted at a time and registered onto the slave AR channel.
//   The granted master index is queued in an in-order routing FIFO, and R
//   beats are steered back to the FIFO head master until rlast.
//   Build option: define AXI_SLV_RD_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest requesting index wins). The default is round-robin.
// Ports:
//   aclk   : clock, rising edge
//   areset : asynchronous, active-high reset
//   m_if   : master-side bus (LANES = MST_NUM), slave modport
//   s_if   : slave-side bus (LANES = 1), master modport
//
// AR FSM
//   state | meaning
//   IDLE  | AR register empty, may grant a request
//   BUSY  | AR register holds a request, s_arvalid = 1
module axi_slv_rd_arb #(
  parameter int MST_NUM    = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32,
  parameter int OSTD_NUM   = 4
) (
  input  logic aclk,
  input  logic areset,
  axi_slv_rd_arb_if.slave  m_if,
  axi_slv_rd_arb_if.master s_if
);

  localparam int IDX_W = (MST_NUM > 1) ? $clog2(MST_NUM) : 1;
  localparam int PTR_W = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1;
  localparam int CNT_W = $clog2(OSTD_NUM) + 1;
  localparam logic [IDX_W:0]   MST_LIM  = (IDX_W+1)'(MST_NUM);
  localparam logic [CNT_W-1:0] OSTD_LIM = CNT_W'(OSTD_NUM);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W:0]        cand;
  logic                  win_found;
  logic [AXI_ADDR_W-1:0] win_addr;
  logic [3:0]            win_len;
  logic [AXI_ID_W-1:0]   win_id;

  logic [AXI_ADDR_W-1:0] araddr_q;
  logic [3:0]            arlen_q;
  logic [AXI_ID_W-1:0]   arid_q;

  logic                  ar_grant;
  logic                  ar_hs;
  logic                  r_pop;
  logic                  fifo_nempty;

  logic [IDX_W-1:0]      fifo_mem [OSTD_NUM];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [IDX_W-1:0]      head;

  // Search starts at rr_ptr and wraps modulo MST_NUM; the first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < MST_NUM; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= MST_LIM) cand = cand - MST_LIM;
      if (!win_found && m_if.arvalid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    win_id   = '0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr = m_if.araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
        win_len  = m_if.arlen[i*4 +: 4];
        win_id   = m_if.arid[i*AXI_ID_W +: AXI_ID_W];
      end
    end
  end

  // Grant is held off during reset so arready reads 0 while areset is high.
  // The outstanding limit together with a single AR register keeps the FIFO
  // from ever overflowing.
  assign ar_grant    = !areset && (state_q == IDLE) && win_found && (fifo_cnt < OSTD_LIM);
  assign ar_hs       = (state_q == BUSY) && s_if.arready[0];
  assign fifo_nempty = (fifo_cnt != '0);
  assign r_pop       = s_if.rvalid[0] && s_if.rready[0] && s_if.rlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    m_if.arready = '0;
    case (state_q)
      IDLE: if (ar_grant) state_d = BUSY;
      BUSY: if (ar_hs)    state_d = IDLE;
    endcase
    for (int i = 0; i < MST_NUM; i++) begin
      m_if.arready[i] = ar_grant && (win_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      grant_idx <= '0;
    end else if (ar_grant) begin
      araddr_q  <= win_addr;
      arlen_q   <= win_len;
      arid_q    <= win_id;
      grant_idx <= win_idx;
    end
  end

`ifdef AXI_SLV_RD_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rr_ptr <= '0;
    else if (ar_hs) rr_ptr <= (grant_idx == IDX_W'(MST_NUM-1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  assign s_if.arvalid = (state_q == BUSY);
  assign s_if.araddr  = araddr_q;
  assign s_if.arlen   = arlen_q;
  assign s_if.arid    = arid_q;

  // Routing FIFO: pointers wrap naturally because OSTD_NUM is a power of 2.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (ar_hs) wr_ptr <= wr_ptr + 1'b1;
      if (r_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({ar_hs, r_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (ar_hs) fifo_mem[wr_ptr] <= grant_idx;
  end

  assign head = fifo_mem[rd_ptr];

  // Bursts return in issue order, so the FIFO head alone names the owner.
  // With nothing outstanding, R is stalled rather than dropped.
  always_comb begin
    m_if.rvalid = '0;
    s_if.rready = '0;
    for (int i = 0; i < MST_NUM; i++) begin
      if (fifo_nempty && (head == IDX_W'(i))) begin
        m_if.rvalid[i] = s_if.rvalid[0];
        s_if.rready[0] = m_if.rready[i];
      end
    end
  end

  assign m_if.rdata = s_if.rdata;
  assign m_if.rid   = s_if.rid;
  assign m_if.rresp = s_if.rresp;
  assign m_if.rlast = s_if.rlast;

endmodule
